// File: rtl/uart_bus_master_if.sv
// Handshake and bus signals between the UART byte FIFOs, the bus master and the peripheral bus mux.
// Signal names follow the master's point of view (_i into the master, _o out of it).
interface uart_bus_master_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [15:0] address_o;
   logic [7:0]  data_o;
   logic        rd_wr_o;
   logic [7:0]  data_i;
   logic        busy_o;

   modport master (
      input  rx_data_i, rx_valid_i, tx_ready_i, data_i,
      output rx_ready_o, tx_data_o, tx_valid_o, address_o, data_o, rd_wr_o, busy_o
   );

   modport slave (
      output rx_data_i, rx_valid_i, tx_ready_i, data_i,
      input  rx_ready_o, tx_data_o, tx_valid_o, address_o, data_o, rd_wr_o, busy_o
   );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: parses 'W' AH AL D / 'R' AH AL frames from the RX byte stream,
// performs one single-cycle bus access and answers with read data, ACK or NAK on the TX stream.
module uart_bus_master #(
   parameter logic [15:0] IdleAddress   = 16'hFFFF,
   parameter int          ReadLatency   = 1,
   parameter int          TimeoutCycles = 48000000,
   parameter bit          WriteAck      = 1'b1
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   uart_bus_master_if.master bus
);

   localparam logic [7:0] CmdWrite = 8'h57;
   localparam logic [7:0] CmdRead  = 8'h52;
   localparam logic [7:0] ByteAck  = 8'h06;
   localparam logic [7:0] ByteNak  = 8'h15;

   localparam int             CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam logic [CntW-1:0] CntMax  = '1;
   localparam int             LatW    = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
   localparam logic [LatW-1:0] LatLast = LatW'((ReadLatency > 0) ? ReadLatency - 1 : 0);

   typedef enum logic [2:0] {
      IDLE, ADDR_H, ADDR_L, DATA, BUS_WR, BUS_RD, RD_WAIT, RESP
   } state_t;

   state_t          state;
   logic            is_write;
   logic [7:0]      addr_h;
   logic [7:0]      addr_l;
   logic [CntW-1:0] tmo_cnt;
   logic [LatW-1:0] lat_cnt;
   logic            accept;

   assign accept = bus.rx_valid_i && bus.rx_ready_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         is_write       <= 1'b0;
         addr_h         <= '0;
         addr_l         <= '0;
         tmo_cnt        <= '0;
         lat_cnt        <= '0;
         bus.rx_ready_o <= 1'b0;
         bus.tx_data_o  <= '0;
         bus.tx_valid_o <= 1'b0;
         bus.address_o  <= IdleAddress;
         bus.data_o     <= '0;
         bus.rd_wr_o    <= 1'b0;
         bus.busy_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.rx_ready_o <= 1'b1;
               bus.busy_o     <= 1'b0;
               tmo_cnt        <= '0;
               if (accept) begin
                  bus.busy_o <= 1'b1;
                  if (bus.rx_data_i == CmdWrite || bus.rx_data_i == CmdRead) begin
                     is_write <= (bus.rx_data_i == CmdWrite);
                     state    <= ADDR_H;
                  end else begin
                     bus.tx_data_o  <= ByteNak;
                     bus.tx_valid_o <= 1'b1;
                     bus.rx_ready_o <= 1'b0;
                     state          <= RESP;
                  end
               end
            end

            ADDR_H, ADDR_L, DATA: begin
               if (accept) begin
                  tmo_cnt <= '0;
                  case (state)
                     ADDR_H: begin
                        addr_h <= bus.rx_data_i;
                        state  <= ADDR_L;
                     end
                     ADDR_L: begin
                        addr_l <= bus.rx_data_i;
                        if (is_write) begin
                           state <= DATA;
                        end else begin
                           bus.address_o  <= {addr_h, bus.rx_data_i};
                           bus.rx_ready_o <= 1'b0;
                           state          <= BUS_RD;
                        end
                     end
                     default: begin
                        bus.address_o  <= {addr_h, addr_l};
                        bus.data_o     <= bus.rx_data_i;
                        bus.rd_wr_o    <= 1'b1;
                        bus.rx_ready_o <= 1'b0;
                        state          <= BUS_WR;
                     end
                  endcase
               end else if (TimeoutCycles != 0 && tmo_cnt == CntLast) begin
                  // Abandoned frame: drop silently, no bus access and no reply
                  tmo_cnt    <= '0;
                  bus.busy_o <= 1'b0;
                  state      <= IDLE;
               end else if (tmo_cnt != CntMax) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            BUS_WR: begin
               bus.address_o <= IdleAddress;
               bus.data_o    <= '0;
               bus.rd_wr_o   <= 1'b0;
               if (WriteAck) begin
                  bus.tx_data_o  <= ByteAck;
                  bus.tx_valid_o <= 1'b1;
                  state          <= RESP;
               end else begin
                  bus.busy_o     <= 1'b0;
                  bus.rx_ready_o <= 1'b1;
                  state          <= IDLE;
               end
            end

            BUS_RD: begin
               // Address is shown for one cycle only, since a read may pop a peripheral FIFO
               bus.address_o <= IdleAddress;
               lat_cnt       <= '0;
               if (ReadLatency == 0) begin
                  bus.tx_data_o  <= bus.data_i;
                  bus.tx_valid_o <= 1'b1;
                  state          <= RESP;
               end else begin
                  state <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (lat_cnt == LatLast) begin
                  bus.tx_data_o  <= bus.data_i;
                  bus.tx_valid_o <= 1'b1;
                  state          <= RESP;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end

            RESP: begin
               if (bus.tx_ready_i) begin
                  bus.tx_valid_o <= 1'b0;
                  bus.busy_o     <= 1'b0;
                  bus.rx_ready_o <= 1'b1;
                  state          <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, read, NAK, timeout, TX stall, mid-frame reset, back-to-back.
module tb_uart_bus_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   int          bus_cnt = 0;
   int          wr_cnt  = 0;
   int          pop_cnt = 0;
   int          tx_cnt  = 0;
   logic [15:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  tx_last = '0;

   uart_bus_master_if bus ();

   uart_bus_master #(
      .IdleAddress   (16'hFFFF),
      .ReadLatency   (1),
      .TimeoutCycles (100),
      .WriteAck      (1'b1)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Registered peripheral model plus bus/TX activity monitor
   always @(posedge clk) begin
      if (bus.address_o != 16'hFFFF) bus_cnt <= bus_cnt + 1;
      if (bus.rd_wr_o) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.address_o;
         wr_data <= bus.data_o;
      end
      if (bus.address_o == 16'h9003 && !bus.rd_wr_o) pop_cnt <= pop_cnt + 1;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
         tx_cnt  <= tx_cnt + 1;
         tx_last <= bus.tx_data_o;
      end
      bus.data_i <= (bus.address_o == 16'h9003) ? 8'h3C : (bus.address_o[7:0] ^ 8'h5A);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      while (!bus.rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rx_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL send_byte %h: rx_ready got %b expected 1 within 200 cycles", b, bus.rx_ready_o);
      end
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx_data_i  = 8'h00;
      bus.rx_valid_i = 1'b0;
      bus.tx_ready_i = 1'b1;
      reset_n = 1'b0;
      tick(2);
      checks++;
      if ({bus.rx_ready_o, bus.tx_valid_o, bus.rd_wr_o, bus.busy_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: rx_ready/tx_valid/rd_wr/busy got %b expected 0000",
                  {bus.rx_ready_o, bus.tx_valid_o, bus.rd_wr_o, bus.busy_o});
      end
      checks++;
      if (bus.address_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_addr: got %h expected ffff", bus.address_o);
      end
      checks++;
      if ({bus.tx_data_o, bus.data_o} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: tx_data/data got %h expected 0000", {bus.tx_data_o, bus.data_o});
      end
      reset_n = 1'b1;
      tick(1);
      checks++;
      if (bus.rx_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rx_ready/busy got %b%b expected 10", bus.rx_ready_o, bus.busy_o);
      end
   endtask

   task automatic test_write();
      int b0, w0, t0;
      b0 = bus_cnt; w0 = wr_cnt; t0 = tx_cnt;
      send_byte(8'h57); send_byte(8'h90); send_byte(8'h00); send_byte(8'hA5);
      checks++;
      if ({bus.rd_wr_o, bus.address_o, bus.data_o} !== {1'b1, 16'h9000, 8'hA5}) begin
         errors++;
         $display("FAIL wr_strobe: rd_wr/addr/data got %b %h %h expected 1 9000 a5",
                  bus.rd_wr_o, bus.address_o, bus.data_o);
      end
      tick(1);
      checks++;
      if (bus.rd_wr_o !== 1'b0 || bus.address_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL wr_release: rd_wr/addr got %b %h expected 0 ffff", bus.rd_wr_o, bus.address_o);
      end
      checks++;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h06) begin
         errors++;
         $display("FAIL wr_ack: tx_valid/tx_data got %b %h expected 1 06", bus.tx_valid_o, bus.tx_data_o);
      end
      tick(3);
      checks++;
      if (wr_cnt - w0 != 1 || wr_addr !== 16'h9000 || wr_data !== 8'hA5 || bus_cnt - b0 != 1) begin
         errors++;
         $display("FAIL wr_bus: writes %0d addr %h data %h cycles %0d expected 1 9000 a5 1",
                  wr_cnt - w0, wr_addr, wr_data, bus_cnt - b0);
      end
      checks++;
      if (tx_cnt - t0 != 1 || tx_last !== 8'h06 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wr_tx: tx bytes %0d last %h busy %b expected 1 06 0", tx_cnt - t0, tx_last, bus.busy_o);
      end
   endtask

   task automatic test_read();
      int b0, p0, t0, w0;
      b0 = bus_cnt; p0 = pop_cnt; t0 = tx_cnt; w0 = wr_cnt;
      send_byte(8'h52); send_byte(8'h90); send_byte(8'h03);
      checks++;
      if ({bus.address_o, bus.rd_wr_o, bus.rx_ready_o} !== {16'h9003, 2'b00}) begin
         errors++;
         $display("FAIL rd_addr: addr/rd_wr/rx_ready got %h %b %b expected 9003 0 0",
                  bus.address_o, bus.rd_wr_o, bus.rx_ready_o);
      end
      tick(1);
      checks++;
      if (bus.address_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL rd_release: addr got %h expected ffff", bus.address_o);
      end
      tick(1);
      checks++;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h3C) begin
         errors++;
         $display("FAIL rd_data: tx_valid/tx_data got %b %h expected 1 3c", bus.tx_valid_o, bus.tx_data_o);
      end
      tick(3);
      checks++;
      if (pop_cnt - p0 != 1 || bus_cnt - b0 != 1 || wr_cnt - w0 != 0) begin
         errors++;
         $display("FAIL rd_bus: pops %0d cycles %0d writes %0d expected 1 1 0",
                  pop_cnt - p0, bus_cnt - b0, wr_cnt - w0);
      end
      checks++;
      if (tx_cnt - t0 != 1 || tx_last !== 8'h3C) begin
         errors++;
         $display("FAIL rd_tx: tx bytes %0d last %h expected 1 3c", tx_cnt - t0, tx_last);
      end
   endtask

   task automatic test_nak();
      int b0, t0;
      b0 = bus_cnt; t0 = tx_cnt;
      send_byte(8'h41);
      checks++;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h15 || bus.rx_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL nak_resp: tx_valid/tx_data/rx_ready got %b %h %b expected 1 15 0",
                  bus.tx_valid_o, bus.tx_data_o, bus.rx_ready_o);
      end
      tick(3);
      checks++;
      if (bus_cnt - b0 != 0 || tx_cnt - t0 != 1 || tx_last !== 8'h15) begin
         errors++;
         $display("FAIL nak_bus: cycles %0d tx bytes %0d last %h expected 0 1 15",
                  bus_cnt - b0, tx_cnt - t0, tx_last);
      end
      send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
      tick(5);
      checks++;
      if (bus_cnt - b0 != 1 || tx_cnt - t0 != 2 || tx_last !== 8'h6E) begin
         errors++;
         $display("FAIL nak_next_read: cycles %0d tx bytes %0d last %h expected 1 2 6e",
                  bus_cnt - b0, tx_cnt - t0, tx_last);
      end
   endtask

   task automatic test_timeout();
      int p0, t0, w0;
      p0 = pop_cnt; t0 = tx_cnt; w0 = wr_cnt;
      send_byte(8'h57); send_byte(8'h90);
      tick(99);
      checks++;
      if (bus.busy_o !== 1'b1 || bus.rx_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL tmo_early: busy/rx_ready got %b%b expected 11 after 99 idle clocks",
                  bus.busy_o, bus.rx_ready_o);
      end
      tick(1);
      checks++;
      if (bus.busy_o !== 1'b0 || tx_cnt - t0 != 0) begin
         errors++;
         $display("FAIL tmo_abort: busy %b tx bytes %0d expected 0 0 after 100 idle clocks",
                  bus.busy_o, tx_cnt - t0);
      end
      send_byte(8'h52); send_byte(8'h90); send_byte(8'h03);
      tick(5);
      checks++;
      if (wr_cnt - w0 != 0 || pop_cnt - p0 != 1 || tx_cnt - t0 != 1 || tx_last !== 8'h3C) begin
         errors++;
         $display("FAIL tmo_next_frame: writes %0d pops %0d tx bytes %0d last %h expected 0 1 1 3c",
                  wr_cnt - w0, pop_cnt - p0, tx_cnt - t0, tx_last);
      end
   endtask

   task automatic test_tx_stall();
      int p0, t0, bad;
      p0 = pop_cnt; t0 = tx_cnt; bad = 0;
      bus.tx_ready_i = 1'b0;
      send_byte(8'h52); send_byte(8'h90); send_byte(8'h03);
      tick(2);
      for (int i = 0; i < 50; i++) begin
         if (!(bus.tx_valid_o === 1'b1 && bus.tx_data_o === 8'h3C &&
               bus.rx_ready_o === 1'b0 && bus.busy_o === 1'b1)) bad++;
         tick(1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold: unstable cycles got %0d expected 0", bad);
      end
      bus.tx_ready_i = 1'b1;
      tick(1);
      checks++;
      if ({bus.tx_valid_o, bus.busy_o, bus.rx_ready_o} !== 3'b001) begin
         errors++;
         $display("FAIL stall_release: tx_valid/busy/rx_ready got %b expected 001",
                  {bus.tx_valid_o, bus.busy_o, bus.rx_ready_o});
      end
      checks++;
      if (pop_cnt - p0 != 1 || tx_cnt - t0 != 1 || tx_last !== 8'h3C) begin
         errors++;
         $display("FAIL stall_bus: pops %0d tx bytes %0d last %h expected 1 1 3c",
                  pop_cnt - p0, tx_cnt - t0, tx_last);
      end
   endtask

   task automatic test_reset_midframe();
      int t0, w0;
      t0 = tx_cnt; w0 = wr_cnt;
      send_byte(8'h57); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h11);
      checks++;
      if (bus.rd_wr_o !== 1'b1 || bus.address_o !== 16'hABCD) begin
         errors++;
         $display("FAIL mid_strobe: rd_wr/addr got %b %h expected 1 abcd", bus.rd_wr_o, bus.address_o);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.rd_wr_o, bus.address_o, bus.busy_o, bus.tx_valid_o} !== {1'b0, 16'hFFFF, 2'b00}) begin
         errors++;
         $display("FAIL mid_async: rd_wr/addr/busy/tx_valid got %b %h %b %b expected 0 ffff 0 0",
                  bus.rd_wr_o, bus.address_o, bus.busy_o, bus.tx_valid_o);
      end
      tick(2);
      reset_n = 1'b1;
      tick(10);
      checks++;
      if (tx_cnt - t0 != 0 || wr_cnt - w0 != 0 || bus.rx_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_after: tx bytes %0d writes %0d rx_ready %b expected 0 0 1",
                  tx_cnt - t0, wr_cnt - w0, bus.rx_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      int t0, w0;
      t0 = tx_cnt; w0 = wr_cnt;
      send_byte(8'h57); send_byte(8'h12); send_byte(8'h00); send_byte(8'h77);
      send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
      tick(6);
      checks++;
      if (wr_cnt - w0 != 1 || wr_addr !== 16'h1200 || wr_data !== 8'h77) begin
         errors++;
         $display("FAIL b2b_write: writes %0d addr %h data %h expected 1 1200 77",
                  wr_cnt - w0, wr_addr, wr_data);
      end
      // Read of ffff: model answers ff ^ 5a = a5
      checks++;
      if (tx_cnt - t0 != 2 || tx_last !== 8'hA5 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_tx: tx bytes %0d last %h busy %b expected 2 a5 0",
                  tx_cnt - t0, tx_last, bus.busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nak();
      test_timeout();
      test_tx_stall();
      test_reset_midframe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
